// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / sequencing control slice.
package pipe_ctrl_pkg;

    localparam int unsigned RA_W    = 4;
    localparam int unsigned OP_W    = 2;
    localparam int unsigned FUNCT_W = 6;

    // Register index that aliases the PC
    localparam logic [RA_W-1:0] PC_REG = RA_W'(15);

    // instr[27:26] major opcode classes
    localparam logic [OP_W-1:0] OP_DP  = 2'b00;
    localparam logic [OP_W-1:0] OP_MEM = 2'b01;
    localparam logic [OP_W-1:0] OP_BR  = 2'b10;

    // Operand source select driven to the execute-stage muxes
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Write-class state carried down the pipe per instruction
    typedef struct packed {
        logic [RA_W-1:0] wa3;
        logic            regw;
        logic            ld;
        logic            pcs;
    } stage_ctrl_t;

    // Pick the youngest in-flight producer of a source register; the PC alias is never bypassed
    function automatic fwd_sel_t fwd_select(
        input logic [RA_W-1:0] ra,
        input stage_ctrl_t     m,
        input stage_ctrl_t     w
    );
        fwd_sel_t sel;
        sel = FWD_RF;
        if (ra != PC_REG) begin
            if (m.regw && (m.wa3 == ra)) begin
                sel = FWD_MEM;
            end else if (w.regw && (w.wa3 == ra)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/instr_class_dec.sv
// Instruction class decode: register-write, load, branch and PC-write flags for one instruction.
module instr_class_dec
    import pipe_ctrl_pkg::*;
(
    input  logic               valid,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [RA_W-1:0]    wa3,
    output logic               regw,
    output logic               ld,
    output logic               br,
    output logic               pcs
);

    logic mem_c;
    logic ldr_c;
    logic dp_wr_c;
    logic unused_funct;

    // Immediate flag plays no part in write classification
    assign unused_funct = funct[5];

    // Classify: CMP/CMN/TST/TEQ (cmd 10xx) set flags only and never write a register
    always_comb begin
        mem_c   = (op == OP_MEM);
        ldr_c   = mem_c & funct[0];
        dp_wr_c = (op == OP_DP) && (funct[4:3] != 2'b10);
        br      = valid & (op == OP_BR);
        ld      = valid & ldr_c;
        regw    = valid & (dp_wr_c | ldr_c);
        pcs     = valid & ((regw & (wa3 == PC_REG)) | (op == OP_BR));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / sequencing controller: E/M/W write-class pipe, load-use stall, PC-write flush, operand forwarding.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_d,
    input  logic [OP_W-1:0]    op_d,
    input  logic [FUNCT_W-1:0] funct_d,
    input  logic [RA_W-1:0]    ra1_d,
    input  logic [RA_W-1:0]    ra2_d,
    input  logic [RA_W-1:0]    wa3_d,
    input  logic               cond_ex_e,
    input  logic               branch_taken_e,
    output logic               stall_f,
    output logic               stall_d,
    output logic               flush_d,
    output logic               flush_e,
    output logic [1:0]         fwd_a_e,
    output logic [1:0]         fwd_b_e
);

    logic            regw_d;
    logic            ld_d;
    logic            br_d;
    logic            pcs_d;
    logic            unused_sig;

    logic [RA_W-1:0] ra1_e_q;
    logic [RA_W-1:0] ra2_e_q;
    stage_ctrl_t     e_q;
    stage_ctrl_t     m_q;
    stage_ctrl_t     w_q;

    logic            ld_stall_c;
    logic            pc_pend_c;
    fwd_sel_t        fwd_a_c;
    fwd_sel_t        fwd_b_c;

    instr_class_dec u_dec (
        .valid (valid_d),
        .op    (op_d),
        .funct (funct_d),
        .wa3   (wa3_d),
        .regw  (regw_d),
        .ld    (ld_d),
        .br    (br_d),
        .pcs   (pcs_d)
    );

    // Branch-ness is already folded into pcs; load flag is only consulted in E
    assign unused_sig = br_d | m_q.ld | w_q.ld;

    // D->E stage: a flush inserts an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra1_e_q <= '0;
            ra2_e_q <= '0;
            e_q     <= '0;
        end else if (flush_e) begin
            ra1_e_q <= '0;
            ra2_e_q <= '0;
            e_q     <= '0;
        end else begin
            ra1_e_q  <= ra1_d;
            ra2_e_q  <= ra2_d;
            e_q.wa3  <= wa3_d;
            e_q.regw <= regw_d;
            e_q.ld   <= ld_d;
            e_q.pcs  <= pcs_d;
        end
    end

    // E->M stage: a failed condition cancels the register write and PC write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
        end else begin
            m_q.wa3  <= e_q.wa3;
            m_q.regw <= e_q.regw & cond_ex_e;
            m_q.ld   <= e_q.ld;
            m_q.pcs  <= e_q.pcs & cond_ex_e;
        end
    end

    // M->W stage: plain copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q <= '0;
        end else begin
            w_q <= m_q;
        end
    end

    // Hazard equations and forward selects, purely from stage state and D inputs
    always_comb begin
        ld_stall_c = e_q.ld & e_q.regw & valid_d
                   & ((e_q.wa3 == ra1_d) | (e_q.wa3 == ra2_d));
        pc_pend_c  = pcs_d | e_q.pcs | m_q.pcs;
        fwd_a_c    = fwd_select(ra1_e_q, m_q, w_q);
        fwd_b_c    = fwd_select(ra2_e_q, m_q, w_q);

        stall_f    = ld_stall_c | pc_pend_c;
        stall_d    = ld_stall_c;
        flush_d    = pc_pend_c | w_q.pcs | branch_taken_e;
        flush_e    = ld_stall_c | branch_taken_e;
        fwd_a_e    = fwd_a_c;
        fwd_b_e    = fwd_b_c;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed + randomized bench for pipe_hazard_ctrl against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic       valid_d;
    logic [1:0] op_d;
    logic [5:0] funct_d;
    logic [3:0] ra1_d;
    logic [3:0] ra2_d;
    logic [3:0] wa3_d;
    logic       cond_ex_e;
    logic       branch_taken_e;
    logic       stall_f;
    logic       stall_d;
    logic       flush_d;
    logic       flush_e;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;

    int n_vec;
    int n_err;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_d        (valid_d),
        .op_d           (op_d),
        .funct_d        (funct_d),
        .ra1_d          (ra1_d),
        .ra2_d          (ra2_d),
        .wa3_d          (wa3_d),
        .cond_ex_e      (cond_ex_e),
        .branch_taken_e (branch_taken_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .fwd_a_e        (fwd_a_e),
        .fwd_b_e        (fwd_b_e)
    );

    always #5 clk = ~clk;

    // Instruction as seen by the model: its sources, destination and effects
    typedef struct {
        logic [3:0] src_a;
        logic [3:0] src_b;
        logic [3:0] dst;
        bit         writes;
        bit         loads;
        bit         pc_write;
    } minstr_t;

    minstr_t in_e, in_m, in_w;

    // Encodings: ADD/SUB/MOV data-proc funct = {I, cmd[3:0], S}; LDR has L=funct[0]
    localparam logic [5:0] F_ADD = 6'b001000;
    localparam logic [5:0] F_SUB = 6'b000100;
    localparam logic [5:0] F_MOV = 6'b011010;
    localparam logic [5:0] F_LDR = 6'b011001;
    localparam logic [5:0] F_B   = 6'b100000;

    function automatic minstr_t empty_instr();
        minstr_t r;
        r.src_a = 4'd0; r.src_b = 4'd0; r.dst = 4'd0;
        r.writes = 0; r.loads = 0; r.pc_write = 0;
        return r;
    endfunction

    // What the instruction in D does, by mnemonic class
    function automatic minstr_t classify(input logic v, input logic [1:0] op, input logic [5:0] f,
                                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        minstr_t r;
        int cmd;
        bit flag_only;
        bit is_ldr;
        cmd       = int'(f[4:1]);
        flag_only = (cmd == 8) || (cmd == 9) || (cmd == 10) || (cmd == 11);
        is_ldr    = (op == 2'b01) && f[0];
        r.src_a    = a;
        r.src_b    = b;
        r.dst      = d;
        r.writes   = v && (((op == 2'b00) && !flag_only) || is_ldr);
        r.loads    = v && is_ldr;
        r.pc_write = v && ((r.writes && d == 4'd15) || op == 2'b10);
        return r;
    endfunction

    function automatic int fwd_of(input logic [3:0] src);
        if (src == 4'd15) return 0;
        if (in_m.writes && in_m.dst == src) return 2;
        if (in_w.writes && in_w.dst == src) return 1;
        return 0;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_stall_f"}, 8'(stall_f), 8'd0);
        check_val({tag, "_stall_d"}, 8'(stall_d), 8'd0);
        check_val({tag, "_flush_d"}, 8'(flush_d), 8'd0);
        check_val({tag, "_flush_e"}, 8'(flush_e), 8'd0);
        check_val({tag, "_fwd_a"},   8'(fwd_a_e), 8'd0);
        check_val({tag, "_fwd_b"},   8'(fwd_b_e), 8'd0);
    endtask

    // One pipeline cycle: drive D, compare against model mid-cycle, then advance model
    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] d,
                        input logic cond, input logic bt);
        minstr_t in_d;
        minstr_t nxt_m;
        bit ls, pp, e_flush;
        @(posedge clk);
        #1;
        valid_d = v; op_d = op; funct_d = f; ra1_d = a; ra2_d = b; wa3_d = d;
        cond_ex_e = cond; branch_taken_e = bt;
        #4;
        in_d    = classify(v, op, f, a, b, d);
        ls      = in_e.loads && in_e.writes && v && (in_e.dst == a || in_e.dst == b);
        pp      = in_d.pc_write || in_e.pc_write || in_m.pc_write;
        e_flush = ls || bt;
        check_val("stall_f", 8'(stall_f), 8'(ls || pp));
        check_val("stall_d", 8'(stall_d), 8'(ls));
        check_val("flush_d", 8'(flush_d), 8'(pp || in_w.pc_write || bt));
        check_val("flush_e", 8'(flush_e), 8'(e_flush));
        check_val("fwd_a_e", 8'(fwd_a_e), 8'(fwd_of(in_e.src_a)));
        check_val("fwd_b_e", 8'(fwd_b_e), 8'(fwd_of(in_e.src_b)));
        nxt_m          = in_e;
        nxt_m.writes   = in_e.writes && cond;
        nxt_m.pc_write = in_e.pc_write && cond;
        in_w = in_m;
        in_m = nxt_m;
        in_e = e_flush ? empty_instr() : in_d;
    endtask

    task automatic bubble();
        step(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    function automatic logic [3:0] rand_reg();
        if ($urandom_range(0, 7) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        valid_d = 1'b0; op_d = 2'b00; funct_d = 6'd0;
        ra1_d = 4'd0; ra2_d = 4'd0; wa3_d = 4'd0;
        cond_ex_e = 1'b1; branch_taken_e = 1'b0;
        in_e = empty_instr(); in_m = empty_instr(); in_w = empty_instr();

        // Reset state
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bubble();

        // Back-to-back ALU dependence: M forward, then W forward, no stalls
        step(1'b1, 2'b00, F_ADD, 4'd2, 4'd3, 4'd1, 1'b1, 1'b0);   // ADD r1,r2,r3
        step(1'b1, 2'b00, F_ADD, 4'd1, 4'd3, 4'd2, 1'b1, 1'b0);   // ADD r2,r1,r3
        step(1'b1, 2'b00, F_ADD, 4'd1, 4'd3, 4'd5, 1'b1, 1'b0);   // ADD r5,r1,r3
        check_val("s1_fwd_mem", 8'(fwd_a_e), 8'd2);
        check_val("s1_nostall", 8'(stall_f), 8'd0);
        bubble();
        check_val("s1_fwd_wb", 8'(fwd_a_e), 8'd1);
        bubble(); bubble(); bubble();

        // Load-use: one stall cycle, then W forward
        step(1'b1, 2'b01, F_LDR, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);   // LDR r4,[r0]
        step(1'b1, 2'b00, F_SUB, 4'd4, 4'd6, 4'd5, 1'b1, 1'b0);   // SUB r5,r4,r6
        check_val("s2_stall_f", 8'(stall_f), 8'd1);
        check_val("s2_flush_e", 8'(flush_e), 8'd1);
        step(1'b1, 2'b00, F_SUB, 4'd4, 4'd6, 4'd5, 1'b1, 1'b0);   // held in D
        check_val("s2_released", 8'(stall_d), 8'd0);
        bubble();
        check_val("s2_fwd_wb", 8'(fwd_a_e), 8'd1);
        bubble(); bubble(); bubble();

        // Taken branch: flush D and E in the resolve cycle only
        step(1'b1, 2'b10, F_B, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 6'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
        check_val("s3_flush_e", 8'(flush_e), 8'd1);
        bubble(); bubble(); bubble(); bubble();

        // PC write through MOV r15: four flushed D slots
        step(1'b1, 2'b00, F_MOV, 4'd0, 4'd2, 4'd15, 1'b1, 1'b0);
        bubble(); bubble(); bubble();
        check_val("s4_flush_w", 8'(flush_d), 8'd1);
        bubble();
        check_val("s4_release", 8'(flush_d), 8'd0);

        // Condition-failed writer never forwards
        step(1'b1, 2'b00, F_ADD, 4'd2, 4'd3, 4'd1, 1'b1, 1'b0);
        step(1'b1, 2'b00, F_ADD, 4'd1, 4'd3, 4'd2, 1'b0, 1'b0);   // ADD r1 fails cond in E
        step(1'b1, 2'b00, F_ADD, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0);
        check_val("s5_nofwd", 8'(fwd_a_e), 8'd0);
        bubble(); bubble(); bubble();

        // Asynchronous reset in the middle of a load-use stall
        step(1'b1, 2'b01, F_LDR, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0);
        step(1'b1, 2'b00, F_SUB, 4'd4, 4'd6, 4'd5, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        valid_d = 1'b0;
        branch_taken_e = 1'b0;
        #1;
        check_all_zero("async_rst");
        in_e = empty_instr(); in_m = empty_instr(); in_w = empty_instr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bubble(); bubble();
        #1;
        check_all_zero("post_rst");

        // Randomized instruction stream
        for (int i = 0; i < 400; i++) begin
            logic       v;
            logic [1:0] op;
            v  = ($urandom_range(0, 9) != 0);
            op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            step(v, op, 6'($urandom_range(0, 63)), rand_reg(), rand_reg(), rand_reg(),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
